// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter and receiver.
package uart_pkg;

    localparam int DATA_W     = 8;
    localparam int FR_W       = 12;
    localparam int FRAME_BITS = 11;

    // One state set serves both directions: start, data, parity, stop.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, falling-edge start detect,
// mid-bit sampling, even-parity check and stop-bit validation.
module uart_rx #(
    parameter int DATA_W = 8,
    parameter int FR_W   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic [FR_W-1:0]   work_fr,
    output logic [DATA_W-1:0] data,
    output logic              parity_ok,
    output logic              ready
);
    import uart_pkg::*;

    localparam int IDX_W = $clog2(DATA_W);

    logic              sync1, sync2, rx_prev;
    uart_state_t       state, state_next;
    logic [FR_W-1:0]   cnt, period, work_eff;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shift;
    logic              par_bit;
    logic              bit_end, mid, fall;

    // Bit periods below 2 cycles cannot hold a mid-point sample.
    assign work_eff = (work_fr < FR_W'(2)) ? FR_W'(2) : work_fr;
    // cnt is the offset from the nominal start of the current bit.
    assign bit_end  = (cnt == period - FR_W'(1));
    assign mid      = (cnt == (period >> 1));
    assign fall     = rx_prev && !sync2;

    // Synchronizer plus one extra flop used only for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state: glitchy start and any stop sample end the frame early.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (fall) state_next = S_START;
            S_START:  if (mid && sync2) state_next = S_IDLE;
                      else if (bit_end) state_next = S_DATA;
            S_DATA:   if (bit_end && idx == IDX_W'(DATA_W-1)) state_next = S_PARITY;
            S_PARITY: if (bit_end) state_next = S_STOP;
            S_STOP:   if (mid) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Bit timing, sampling and result delivery.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            period    <= '0;
            idx       <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            data      <= '0;
            parity_ok <= 1'b0;
            ready     <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (state == S_IDLE) begin
                idx <= '0;
                // The edge cycle is offset 0, so the first START cycle is offset 1.
                if (fall) begin
                    cnt    <= FR_W'(1);
                    period <= work_eff;
                end else begin
                    cnt <= '0;
                end
            end else begin
                cnt <= bit_end ? '0 : cnt + FR_W'(1);
                case (state)
                    S_DATA: begin
                        if (mid)     shift <= {sync2, shift[DATA_W-1:1]};
                        if (bit_end) idx   <= idx + IDX_W'(1);
                    end
                    S_PARITY: if (mid) par_bit <= sync2;
                    S_STOP: if (mid && sync2) begin
                        data      <= shift;
                        parity_ok <= (par_bit == ^shift);
                        ready     <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart.sv
// UART top: inline transmitter FSM plus one receiver instance.
module uart #(
    parameter int DATA_W = 8,
    parameter int FR_W   = 12
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RX,
    input  logic              START,
    input  logic [DATA_W-1:0] DATA_TX,
    input  logic [FR_W-1:0]   WORK_FR,
    output logic              TX,
    output logic [DATA_W-1:0] DATA_RX,
    output logic              PARITY_RX,
    output logic              READY_TX,
    output logic              READY
);
    import uart_pkg::*;

    localparam int IDX_W = $clog2(DATA_W);

    uart_state_t       tx_state, tx_next;
    logic [FR_W-1:0]   tx_cnt, tx_period, work_eff;
    logic [IDX_W-1:0]  tx_idx;
    logic [DATA_W-1:0] tx_data;
    logic              tx_bit_end, tx_line, accept;

    assign work_eff   = (WORK_FR < FR_W'(2)) ? FR_W'(2) : WORK_FR;
    assign tx_bit_end = (tx_cnt == tx_period - FR_W'(1));
    assign accept     = (tx_state == S_IDLE) && START;
    // Line is forced idle while reset is held, not just after it is sampled.
    assign TX         = tx_line | RESET;

    // Transmitter state register.
    always_ff @(posedge CLK) begin
        if (RESET) tx_state <= S_IDLE;
        else       tx_state <= tx_next;
    end

    // Transmitter next-state and line/ready outputs.
    always_comb begin
        tx_next  = tx_state;
        tx_line  = 1'b1;
        READY_TX = 1'b0;
        case (tx_state)
            S_IDLE: begin
                READY_TX = 1'b1;
                if (START) tx_next = S_START;
            end
            S_START: begin
                tx_line = 1'b0;
                if (tx_bit_end) tx_next = S_DATA;
            end
            S_DATA: begin
                tx_line = tx_data[tx_idx];
                if (tx_bit_end && tx_idx == IDX_W'(DATA_W-1)) tx_next = S_PARITY;
            end
            S_PARITY: begin
                tx_line = ^tx_data;
                if (tx_bit_end) tx_next = S_STOP;
            end
            S_STOP: begin
                if (tx_bit_end) tx_next = S_IDLE;
            end
            default: tx_next = S_IDLE;
        endcase
    end

    // Transmitter datapath: byte and bit period are frozen for the whole frame.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_cnt    <= '0;
            tx_period <= '0;
            tx_idx    <= '0;
            tx_data   <= '0;
        end else if (accept) begin
            tx_data   <= DATA_TX;
            tx_period <= work_eff;
            tx_cnt    <= '0;
            tx_idx    <= '0;
        end else if (tx_state != S_IDLE) begin
            tx_cnt <= tx_bit_end ? '0 : tx_cnt + FR_W'(1);
            if (tx_state == S_DATA && tx_bit_end) tx_idx <= tx_idx + IDX_W'(1);
        end
    end

    uart_rx #(.DATA_W(DATA_W), .FR_W(FR_W)) u_rx (
        .clk       (CLK),
        .reset     (RESET),
        .rx        (RX),
        .work_fr   (WORK_FR),
        .data      (DATA_RX),
        .parity_ok (PARITY_RX),
        .ready     (READY)
    );

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart: loopback and externally driven frames,
// with a scoreboard of expected received bytes checked on every READY.
module tb_uart;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  data_tx;
    logic [11:0] work_fr;
    logic        tx, ready_tx, ready, parity_rx;
    logic [7:0]  data_rx;
    logic        loop, rx_drv, rx_line;

    typedef struct packed { logic [7:0] d; logic p; } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int failures = 0;
    int ready_cnt = 0;
    logic ready_prev = 1'b0;
    logic [10:0] frm;

    assign rx_line = loop ? tx : rx_drv;

    always #5 clk = ~clk;

    uart #(.DATA_W(8), .FR_W(12)) dut (
        .CLK(clk), .RESET(reset), .RX(rx_line), .START(start),
        .DATA_TX(data_tx), .WORK_FR(work_fr), .TX(tx),
        .DATA_RX(data_rx), .PARITY_RX(parity_rx),
        .READY_TX(ready_tx), .READY(ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tx(input logic [7:0] d);
        start   = 1'b1;
        data_tx = d;
        tick();
        start   = 1'b0;
    endtask

    // Drive one frame on RX from the bench; parity and stop are explicit.
    task automatic drive_frame(input logic [7:0] d, input logic par, input logic stp, input int p);
        logic [10:0] f;
        f = {stp, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx_drv = f[i];
            repeat (p) tick();
        end
        rx_drv = 1'b1;
    endtask

    task automatic wait_sb_empty(input string tag, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, sb_q.size(), 0);
    endtask

    task automatic wait_ready_tx(input string tag, input int budget);
        int n = 0;
        while (ready_tx !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, ready_tx, 1);
    endtask

    // Scoreboard: every READY must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            exp_t e;
            ready_cnt++;
            chk("ready_single_cycle", ready_prev, 0);
            chk("ready_expected", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_data_rx", data_rx, e.d);
                chk("sb_parity_rx", parity_rx, e.p);
            end
        end
        ready_prev = ready;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int lows;
        reset   = 1'b1;
        start   = 1'b0;
        data_tx = 8'h00;
        work_fr = 12'd16;
        loop    = 1'b1;
        rx_drv  = 1'b1;
        repeat (3) tick();

        // Reset state.
        chk("rst_tx", tx, 1);
        chk("rst_ready_tx", ready_tx, 1);
        chk("rst_data_rx", data_rx, 8'h00);
        chk("rst_parity_rx", parity_rx, 0);
        chk("rst_ready", ready, 0);
        reset = 1'b0;
        repeat (4) tick();

        // Loopback 0xAA at 16 cycles/bit, with WORK_FR changed mid-frame.
        sb_q.push_back('{d: 8'hAA, p: 1'b1});
        rc = ready_cnt;
        frm = {1'b1, ^8'hAA, 8'hAA, 1'b0};
        send_tx(8'hAA);
        chk("aa_ready_tx_low", ready_tx, 0);
        for (int k = 0; k < 176; k++) begin
            chk($sformatf("aa_tx_bit%0d_c%0d", k / 16, k % 16), tx, frm[k / 16]);
            if (k == 40) work_fr = 12'd5;
            tick();
            if (k == 174) chk("aa_ready_tx_last_stop", ready_tx, 0);
        end
        chk("aa_ready_tx_back", ready_tx, 1);
        work_fr = 12'd16;
        wait_sb_empty("aa_rx_done", 200);
        chk("aa_ready_count", ready_cnt - rc, 1);
        chk("aa_data_rx", data_rx, 8'hAA);
        chk("aa_parity_rx", parity_rx, 1);

        // Loopback at WORK_FR = 2224: busy exactly 11 bit periods.
        work_fr = 12'(10416);
        sb_q.push_back('{d: 8'b10101010, p: 1'b1});
        send_tx(8'b10101010);
        repeat (11 * 2224 - 1) tick();
        chk("slow_ready_tx_busy", ready_tx, 0);
        tick();
        chk("slow_ready_tx_idle", ready_tx, 1);
        wait_sb_empty("slow_rx_done", 100);
        chk("slow_data_rx", data_rx, 8'hAA);
        work_fr = 12'd16;
        repeat (10) tick();

        // External frame 0x01 with parity forced wrong: delivered, PARITY_RX=0.
        loop = 1'b0;
        sb_q.push_back('{d: 8'h01, p: 1'b0});
        drive_frame(8'h01, 1'b0, 1'b1, 16);
        wait_sb_empty("ext01_rx_done", 100);
        chk("ext01_parity_rx", parity_rx, 0);
        repeat (20) tick();

        // Short low glitch, then a valid 0x55.
        rc = ready_cnt;
        rx_drv = 1'b0;
        repeat (3) tick();
        rx_drv = 1'b1;
        repeat (40) tick();
        chk("glitch_no_ready", ready_cnt - rc, 0);
        sb_q.push_back('{d: 8'h55, p: 1'b1});
        drive_frame(8'h55, ^8'h55, 1'b1, 16);
        wait_sb_empty("glitch_next_frame", 100);
        chk("glitch_next_data", data_rx, 8'h55);
        repeat (20) tick();

        // Framing error: stop bit low.
        rc = ready_cnt;
        drive_frame(8'h3C, ^8'h3C, 1'b0, 16);
        repeat (40) tick();
        chk("frame_err_no_ready", ready_cnt - rc, 0);
        chk("frame_err_data_kept", data_rx, 8'h55);
        chk("frame_err_parity_kept", parity_rx, 1);

        // START while busy is ignored: exactly one frame leaves the transmitter.
        loop = 1'b1;
        repeat (10) tick();
        rc = ready_cnt;
        sb_q.push_back('{d: 8'h0F, p: 1'b1});
        send_tx(8'h0F);
        repeat (20) tick();
        send_tx(8'hFF);
        chk("busy_ready_tx_low", ready_tx, 0);
        wait_ready_tx("busy_frame_done", 200);
        lows = 0;
        for (int k = 0; k < 200; k++) begin
            if (tx !== 1'b1) lows++;
            tick();
        end
        chk("busy_no_second_frame", lows, 0);
        chk("busy_ready_count", ready_cnt - rc, 1);
        chk("busy_data_rx", data_rx, 8'h0F);

        // Reset mid-transmission aborts both directions.
        rc = ready_cnt;
        send_tx(8'h33);
        repeat (50) tick();
        chk("abort_tx_active", ready_tx, 0);
        reset = 1'b1;
        tick();
        chk("abort_tx_high", tx, 1);
        chk("abort_ready_tx", ready_tx, 1);
        chk("abort_data_rx", data_rx, 8'h00);
        tick();
        reset = 1'b0;
        repeat (300) tick();
        chk("abort_no_ready", ready_cnt - rc, 0);
        chk("abort_tx_idle", tx, 1);
        chk("abort_sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
